// File: rtl/alu_simd_self_test_pkg.sv
// Shared definitions for the ALU SIMD self-test block.
//   state_t     : run sequencer states
//   LFSR_MASK   : Galois feedback mask for x^32+x^22+x^2+x+1
//   WARM_CYCLES : idle-operand cycles between start and the first checked vector
package alu_simd_self_test_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WARM = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [31:0] LFSR_MASK   = 32'h8020_0003;
  localparam int          WARM_CYCLES = 2;

endpackage

// File: rtl/lfsr32_galois.sv
// 32-bit right-shifting Galois LFSR.
//   clk, reset : clock, async active-high reset (state returns to SEED)
//   load       : reload SEED (wins over advance)
//   advance    : step the register once
//   q          : current state
module lfsr32_galois #(
  parameter logic [31:0] SEED = 32'h0000_0001,
  parameter logic [31:0] MASK = 32'h8020_0003
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        advance,
  output logic [31:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        q <= SEED;
    else if (load)    q <= SEED;
    else if (advance) q <= (q >> 1) ^ (q[0] ? MASK : 32'h0);
  end

endmodule

// File: rtl/alu_simd_self_test.sv
// Built-in self test for a 4-operand SIMD adder ALU.
// After a start pulse the block idles the operands for WARM_CYCLES cycles,
// then drives TEST_COUNT pseudo-random operand sets from an LFSR, one per
// cycle, and compares the ALU's combinational sum and carry-outs against
// W+Z+Y+X at the closing edge of each cycle.
//   clk, reset                : clock, async active-high reset
//   start                     : one-cycle run request (IDLE/DONE only)
//   busy, done, pass          : status
//   W, Z, Y, X, op, *_controller, CIN_*, result_SIMD_carry_in : ALU stimulus
//   S, COUT_W_X_Y_CIN, COUT_Z_W_X_Y_CIN : ALU response
//   result_SIMD_carry_out     : accepted, not checked
//   vector_count, error_count : vectors checked / saturating mismatch count
module alu_simd_self_test
  import alu_simd_self_test_pkg::*;
#(
  parameter int          Width      = 8,
  parameter int          TEST_COUNT = 10000,
  parameter int          CNT_W      = 16,
  parameter logic [31:0] SEED       = 32'h0000_0001
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [Width-1:0] W,
  output logic [Width-1:0] Z,
  output logic [Width-1:0] Y,
  output logic [Width-1:0] X,
  output logic [1:0]       op,
  output logic             Z_controller,
  output logic             S_controller,
  output logic             W_X_Y_controller,
  output logic             CIN_Z_W_X_Y_CIN,
  output logic [1:0]       CIN_W_X_Y_CIN,
  output logic [1:0]       result_SIMD_carry_in,
  input  logic [Width-1:0] S,
  input  logic [1:0]       COUT_W_X_Y_CIN,
  input  logic             COUT_Z_W_X_Y_CIN,
  input  logic [1:0]       result_SIMD_carry_out,
  output logic [CNT_W-1:0] vector_count,
  output logic [CNT_W-1:0] error_count
);

  state_t           state, state_nxt;
  logic [1:0]       warm_cnt;
  logic [31:0]      lfsr_q;
  logic             launch, in_run, warm_last, run_last;
  logic [Width+1:0] golden;
  logic [1:0]       carry_sum;
  logic [1:0]       err_inc;
  logic [CNT_W:0]   err_sum;
  logic             unused_carry_out;

  // The ALU is only exercised as a plain adder.
  assign op                   = 2'b00;
  assign Z_controller         = 1'b0;
  assign S_controller         = 1'b0;
  assign W_X_Y_controller     = 1'b0;
  assign CIN_Z_W_X_Y_CIN      = 1'b0;
  assign CIN_W_X_Y_CIN        = 2'b00;
  assign result_SIMD_carry_in = 2'b00;
  assign unused_carry_out     = ^result_SIMD_carry_out;

  assign launch    = start && (state == ST_IDLE || state == ST_DONE);
  assign in_run    = (state == ST_RUN);
  assign warm_last = (warm_cnt == 2'(WARM_CYCLES - 1));
  assign run_last  = (vector_count == CNT_W'(TEST_COUNT - 1));

  lfsr32_galois #(
    .SEED (SEED),
    .MASK (LFSR_MASK)
  ) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .load    (launch),
    .advance (in_run),
    .q       (lfsr_q)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE, ST_DONE: if (start)     state_nxt = ST_WARM;
      ST_WARM:          if (warm_last) state_nxt = ST_RUN;
      ST_RUN:           if (run_last)  state_nxt = ST_DONE;
      default:                         state_nxt = ST_IDLE;
    endcase
  end

  // Outputs: operands come straight off the LFSR register during RUN so
  // the vector being checked is the one the LFSR holds this cycle.
  always_comb begin
    busy = (state == ST_WARM) || (state == ST_RUN);
    done = (state == ST_DONE);
    pass = (state == ST_DONE) && (error_count == '0);
    W    = '0;
    Z    = '0;
    Y    = '0;
    X    = '0;
    if (in_run) begin
      W = lfsr_q[0*Width +: Width];
      Z = lfsr_q[1*Width +: Width];
      Y = lfsr_q[2*Width +: Width];
      X = lfsr_q[3*Width +: Width];
    end
  end

  // Reference and per-vector error contribution (0, 1 or 2).
  always_comb begin
    golden    = {2'b00, W} + {2'b00, Z} + {2'b00, Y} + {2'b00, X};
    carry_sum = COUT_W_X_Y_CIN + {1'b0, COUT_Z_W_X_Y_CIN};
    err_inc   = {1'b0, (S != golden[Width-1:0])}
              + {1'b0, (carry_sum != golden[Width+1:Width])};
    err_sum   = {1'b0, error_count} + (CNT_W+1)'(err_inc);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  warm_cnt <= 2'd0;
    else if (state == ST_WARM)  warm_cnt <= warm_cnt + 2'd1;
    else                        warm_cnt <= 2'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vector_count <= '0;
      error_count  <= '0;
    end else if (launch) begin
      vector_count <= '0;
      error_count  <= '0;
    end else if (in_run) begin
      vector_count <= vector_count + CNT_W'(1);
      // Saturate instead of wrapping so a heavily broken ALU never reads clean.
      error_count  <= err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_alu_simd_self_test.sv
// Directed bench: two self-test instances wired to behavioural adder ALUs
// with selectable faults; expected vectors and error counts are derived
// from an independent LFSR/adder model in the bench.
module tb_alu_simd_self_test;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: TEST_COUNT=16, CNT_W=16
  logic       start_a, busy_a, done_a, pass_a;
  logic [7:0] W_a, Z_a, Y_a, X_a, S_a;
  logic [1:0] op_a, cinw_a, simdin_a, cout_wxy_a;
  logic       zc_a, sc_a, wxyc_a, cinz_a, cout_z_a;
  logic [15:0] vc_a, ec_a;
  logic [9:0] s1_a;
  logic [8:0] s2_a;
  int         fault_a;

  // Instance B: TEST_COUNT=7, CNT_W=3
  logic       start_b, busy_b, done_b, pass_b;
  logic [7:0] W_b, Z_b, Y_b, X_b, S_b;
  logic [1:0] op_b, cinw_b, simdin_b, cout_wxy_b;
  logic       zc_b, sc_b, wxyc_b, cinz_b, cout_z_b;
  logic [2:0] vc_b, ec_b;
  logic [9:0] s1_b;
  logic [8:0] s2_b;
  int         fault_b;

  alu_simd_self_test #(.Width(8), .TEST_COUNT(16), .CNT_W(16), .SEED(32'h1)) dut_a (
    .clk(clk), .reset(rst), .start(start_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .W(W_a), .Z(Z_a), .Y(Y_a), .X(X_a), .op(op_a),
    .Z_controller(zc_a), .S_controller(sc_a), .W_X_Y_controller(wxyc_a),
    .CIN_Z_W_X_Y_CIN(cinz_a), .CIN_W_X_Y_CIN(cinw_a), .result_SIMD_carry_in(simdin_a),
    .S(S_a), .COUT_W_X_Y_CIN(cout_wxy_a), .COUT_Z_W_X_Y_CIN(cout_z_a),
    .result_SIMD_carry_out(2'b00), .vector_count(vc_a), .error_count(ec_a));

  alu_simd_self_test #(.Width(8), .TEST_COUNT(7), .CNT_W(3), .SEED(32'h1)) dut_b (
    .clk(clk), .reset(rst), .start(start_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .W(W_b), .Z(Z_b), .Y(Y_b), .X(X_b), .op(op_b),
    .Z_controller(zc_b), .S_controller(sc_b), .W_X_Y_controller(wxyc_b),
    .CIN_Z_W_X_Y_CIN(cinz_b), .CIN_W_X_Y_CIN(cinw_b), .result_SIMD_carry_in(simdin_b),
    .S(S_b), .COUT_W_X_Y_CIN(cout_wxy_b), .COUT_Z_W_X_Y_CIN(cout_z_b),
    .result_SIMD_carry_out(2'b00), .vector_count(vc_b), .error_count(ec_b));

  // Behavioural ALU A: (W+X+Y) first stage, then +Z. Fault 1: S[0] stuck 0,
  // fault 2: Z-stage carry stuck 0.
  always_comb begin
    s1_a       = {2'b00, W_a} + {2'b00, X_a} + {2'b00, Y_a};
    s2_a       = {1'b0, Z_a} + {1'b0, s1_a[7:0]};
    S_a        = s2_a[7:0];
    cout_wxy_a = s1_a[9:8];
    cout_z_a   = s2_a[8];
    if (fault_a == 1) S_a[0]   = 1'b0;
    if (fault_a == 2) cout_z_a = 1'b0;
  end

  // Behavioural ALU B: fault 1 inverts S, fault 2 inverts S and Z-stage carry.
  always_comb begin
    s1_b       = {2'b00, W_b} + {2'b00, X_b} + {2'b00, Y_b};
    s2_b       = {1'b0, Z_b} + {1'b0, s1_b[7:0]};
    S_b        = s2_b[7:0];
    cout_wxy_b = s1_b[9:8];
    cout_z_b   = s2_b[8];
    if (fault_b >= 1) S_b      = ~S_b;
    if (fault_b == 2) cout_z_b = ~cout_z_b;
  end

  logic [31:0] vec [16];
  int exp_s0, exp_cz;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    logic [31:0] n;
    n = {1'b0, s[31:1]};
    if (s[0]) n = n ^ 32'h8020_0003;
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full run on A starting #1 after a rising edge. Start is also pulsed
  // during WARM (cycle 2) and RUN (cycle 10); both must be ignored.
  task automatic run_a(input int exp_err, input bit exp_pass, input string tag);
    start_a = 1'b1;
    @(negedge clk);
    check({tag, ".c0_busy"}, 32'(busy_a), 32'd0);
    tick();
    for (int c = 1; c <= 20; c++) begin
      start_a = (c == 2 || c == 10);
      @(negedge clk);
      check($sformatf("%s.busy%0d", tag, c), 32'(busy_a), 32'(c <= 18));
      check($sformatf("%s.done%0d", tag, c), 32'(done_a), 32'(c >= 19));
      if (c >= 3 && c <= 18)
        check($sformatf("%s.vec%0d", tag, c - 3), {X_a, Y_a, Z_a, W_a}, vec[c-3]);
      else
        check($sformatf("%s.opnd%0d", tag, c), {X_a, Y_a, Z_a, W_a}, 32'd0);
      if (c == 5)
        check({tag, ".ctl"}, 32'({op_a, zc_a, sc_a, wxyc_a, cinz_a, cinw_a, simdin_a}), 32'd0);
      if (c >= 19) begin
        check($sformatf("%s.vc%0d", tag, c), 32'(vc_a), 32'd16);
        check($sformatf("%s.ec%0d", tag, c), 32'(ec_a), 32'(exp_err));
        check($sformatf("%s.pass%0d", tag, c), 32'(pass_a), 32'(exp_pass));
      end else begin
        check($sformatf("%s.pass%0d", tag, c), 32'(pass_a), 32'd0);
      end
      tick();
    end
    start_a = 1'b0;
  endtask

  // Run B from IDLE/DONE: checks saturation mid-run and final state at cycle 10.
  task automatic run_b(input int ec6, input int ec7, input string tag);
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 6) check({tag, ".ec6"}, 32'(ec_b), 32'(ec6));
      if (c == 7) check({tag, ".ec7"}, 32'(ec_b), 32'(ec7));
      if (c == 9) check({tag, ".busy9"}, 32'(busy_b), 32'd1);
      if (c == 10) begin
        check({tag, ".done"}, 32'(done_b), 32'd1);
        check({tag, ".busy"}, 32'(busy_b), 32'd0);
        check({tag, ".vc"}, 32'(vc_b), 32'd7);
        check({tag, ".ec"}, 32'(ec_b), 32'd7);
        check({tag, ".pass"}, 32'(pass_b), 32'd0);
      end
      tick();
    end
  endtask

  initial begin
    logic [31:0] s;
    logic [9:0]  g, lo;
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; fault_a = 0; fault_b = 0;

    // Expected vector stream and fault-dependent error counts.
    s = 32'h1; exp_s0 = 0; exp_cz = 0;
    for (int i = 0; i < 16; i++) begin
      vec[i] = s;
      g  = 10'(s[7:0]) + 10'(s[15:8]) + 10'(s[23:16]) + 10'(s[31:24]);
      lo = 10'(s[7:0]) + 10'(s[23:16]) + 10'(s[31:24]);
      if (g[0]) exp_s0++;
      if (((10'(s[15:8]) + 10'(lo[7:0])) >> 8) != 10'd0) exp_cz++;
      s = lfsr_next(s);
    end

    #12;
    check("rst.busy", 32'(busy_a), 32'd0);
    check("rst.done", 32'(done_a), 32'd0);
    check("rst.pass", 32'(pass_a), 32'd0);
    check("rst.opnd", {X_a, Y_a, Z_a, W_a}, 32'd0);
    check("rst.cnt", {vc_a, ec_a}, 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle.busy", 32'(busy_a), 32'd0);
    end

    run_a(0, 1'b1, "clean");
    run_a(0, 1'b1, "rerun");
    fault_a = 1;
    run_a(exp_s0, exp_s0 == 0, "s0stuck");
    fault_a = 2;
    run_a(exp_cz, exp_cz == 0, "czstuck");
    fault_a = 0;

    // Reset while vector 5 is on the bus (cycle 8).
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (7) tick();
    @(negedge clk);
    check("mid.vec5", {X_a, Y_a, Z_a, W_a}, vec[5]);
    #2 rst = 1'b1;
    #1;
    check("mid.busy", 32'(busy_a), 32'd0);
    check("mid.done", 32'(done_a), 32'd0);
    check("mid.opnd", {X_a, Y_a, Z_a, W_a}, 32'd0);
    check("mid.cnt", {vc_a, ec_a}, 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post.idle", 32'(busy_a), 32'd0);
    end
    run_a(0, 1'b1, "postrst");

    // Saturating counter: S inverted gives exactly 7; S and carry inverted
    // give 14 which must clamp at 7 rather than wrap.
    fault_b = 1;
    run_b(3, 4, "sat1");
    fault_b = 2;
    run_b(6, 7, "sat2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
